// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : irq_pkg
// Description : Shared constants and FSM state encoding for the interrupt
//               request capture / service stage (irq_pending_ctrl).
// Contents    : N_REQ  - number of request lines (encoder is fixed 8x3)
//               IDX_W  - width of the presented index
//               state_t - service FSM states (IDLE / HOLD)
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // IDLE: nothing presented, waiting for a selectable pending line.
    // HOLD: idx/valid frozen until the consumer acknowledges.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder
// Description : Fixed 8-to-3 priority encoder; bit 7 has the highest
//               priority. An all-zero input encodes to index 0, so callers
//               must qualify the result with a non-zero check of the input.
// Ports       : in_vec  [7:0] input  - request vector
//               out_idx [2:0] output - index of the highest set bit
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder (
    input  logic [7:0] in_vec,
    output logic [2:0] out_idx
);

    always_comb begin
        out_idx = 3'd0;
        // Ascending scan: the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < 8; i++) begin
            if (in_vec[i]) begin
                out_idx = 3'(i);
            end
        end
    end

endmodule : priority_encoder
`default_nettype wire

// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_pending_ctrl
// Description : Request capture and service stage in front of an 8x3
//               priority encoder. Raw request lines are double-flop
//               synchronised and rising-edge detected into a sticky pending
//               register. The masked pending vector is priority encoded and
//               the winner is presented on a valid/ack handshake; the index
//               is held stable until acknowledged, and the acknowledge
//               clears that line's pending bit. A new edge on a line that is
//               still pending is dropped and flagged in a sticky overrun bit.
// Ports       : clk      input       - system clock, rising edge
//               rst_n    input       - asynchronous active-low reset
//               req_in   input [7:0] - raw request levels (async to clk)
//               mask     input [7:0] - 1 = line eligible for service
//               ack      input       - consumer accepts idx (only when valid)
//               ovr_clr  input       - pulse, clears all overrun flags
//               valid    output      - idx holds a serviceable request
//               idx      output[2:0] - presented index, 7 = highest priority
//               pending  output[7:0] - pending register, unmasked
//               overrun  output[7:0] - sticky per-line overrun flags
// Revision    : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int N     = N_REQ,   // only 8 is supported (fixed encoder)
    parameter int IDX_W = irq_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    input  logic             ack,
    input  logic             ovr_clr,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     overrun
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [N-1:0]     sync1_q,   sync1_d;
    logic [N-1:0]     sync2_q,   sync2_d;
    logic [N-1:0]     prev_q,    prev_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     overrun_q, overrun_d;
    logic             valid_q,   valid_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    state_t           state_q,   state_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     masked;
    logic [IDX_W-1:0] enc_idx;

    priority_encoder u_enc (
        .in_vec  (masked),
        .out_idx (enc_idx)
    );

    always_comb begin
        // Edge detect on the synchronised level against its delayed copy,
        // so a line held high yields exactly one event.
        rise   = sync2_q & ~prev_q;
        // One-hot clear of the presented line, only on an accepted handshake.
        clr    = (ack && valid_q) ? (N'(1) << idx_q) : '0;
        masked = pending_q & mask;
    end

    // ------------------------------------------------------------------
    // Synchroniser, pending and overrun next state
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d   = req_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        // A rise in the same cycle as its clear re-arms the bit (set wins).
        pending_d = (pending_q & ~clr) | rise;
        // An event hitting a line that stays pending is lost; record it.
        // A fresh overrun beats a simultaneous ovr_clr.
        overrun_d = (overrun_q & ~{N{ovr_clr}}) | (rise & pending_q & ~clr);
    end

    // ------------------------------------------------------------------
    // Service FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (masked != '0) begin
                    idx_d   = enc_idx;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // idx stays frozen; new arrivals and mask changes are
                // only looked at again once back in IDLE.
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            state_q   <= IDLE;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
        end
    end

    assign valid   = valid_q;
    assign idx     = idx_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule : irq_pending_ctrl
`default_nettype wire
